// File: rtl/orde_idx_mgr.sv
`default_nettype none
// ============================================================================
//  Module      : orde_idx_mgr
//  Description : Circular index manager for the read-ordering buffer.
//                Allocates global entry indices in issue order, tracks
//                which entries have received responses, and retires them
//                strictly in order, producing per-block pop strobes and
//                per-block insert / oldest pointers for the CAM stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module orde_idx_mgr #(
    parameter int NUM_PER_BLOCK = 32,
    parameter int NUM_MAX_RD    = 512,
    localparam int NUM_BLOCKS   = NUM_MAX_RD / NUM_PER_BLOCK,
    localparam int IW           = $clog2(NUM_MAX_RD),
    localparam int LW           = $clog2(NUM_PER_BLOCK)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_rdy,
    output logic [IW-1:0]         alloc_idx,
    output logic [NUM_BLOCKS-1:0] empty_idx_valid,
    output logic [LW-1:0]         empty_idx,
    output logic [NUM_BLOCKS-1:0] oldest_idx_valid,
    output logic [LW-1:0]         oldest_idx,
    output logic [NUM_BLOCKS-1:0] oldest_idx_next_valid,
    output logic [LW-1:0]         oldest_idx_next,
    input  logic                  resp_valid,
    input  logic [IW-1:0]         resp_idx,
    output logic [NUM_BLOCKS-1:0] pop_idx_valid,
    output logic [LW-1:0]         pop_idx,
    output logic [IW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic                  err
);

    localparam logic [IW:0] MAX_COUNT = (IW+1)'(NUM_MAX_RD);

    // Registered pointers and per-entry response flags
    logic [IW-1:0]         head;
    logic [IW-1:0]         tail;
    logic [NUM_MAX_RD-1:0] done;

    // Combinational control
    logic          alloc_fire;
    logic          retire;
    logic [IW-1:0] head_nxt;
    logic [IW:0]   count_nxt;
    logic [IW-1:0] resp_off;
    logic          resp_in_window;
    logic          resp_ok;
    logic          resp_legal;
    logic          resp_bad;

    // One-hot block select from the upper index bits
    function automatic logic [NUM_BLOCKS-1:0] blk_onehot(input logic [IW-1:0] idx);
        logic [NUM_BLOCKS-1:0] oh;
        oh = '0;
        oh[idx[IW-1:LW]] = 1'b1;
        return oh;
    endfunction

    assign full  = (count == MAX_COUNT);
    assign empty = (count == '0);

    // No bypass: a full buffer refuses allocation even if a retire is
    // happening in the same cycle.
    assign alloc_rdy  = !full;
    assign alloc_fire = alloc_req && !full;

    // Retire only from registered state, so a response to head shows up
    // as a pop one cycle after it arrives.
    assign retire    = !empty && done[head];
    assign head_nxt  = retire ? head + 1'b1 : head;
    assign count_nxt = count + (IW+1)'(alloc_fire) - (IW+1)'(retire);

    // Outstanding window test: distance from head (mod ring size) must be
    // below count. When full this accepts every index, as it should.
    assign resp_off       = resp_idx - head;
    assign resp_in_window = ({1'b0, resp_off} < count);
    assign resp_ok        = resp_in_window && !done[resp_idx];
    assign resp_legal     = resp_valid && resp_ok;
    assign resp_bad       = resp_valid && !resp_ok;

    assign alloc_idx        = tail;
    assign empty_idx_valid  = full ? '0 : blk_onehot(tail);
    assign empty_idx        = tail[LW-1:0];
    assign oldest_idx_valid = empty ? '0 : blk_onehot(head);
    assign oldest_idx       = head[LW-1:0];

    assign oldest_idx_next_valid = (count_nxt == '0) ? '0 : blk_onehot(head_nxt);
    assign oldest_idx_next       = head_nxt[LW-1:0];

    assign pop_idx_valid = retire ? blk_onehot(head) : '0;
    assign pop_idx       = retire ? head[LW-1:0] : '0;

    // Pointer, occupancy and sticky error update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            head  <= head_nxt;
            count <= count_nxt;
            if (alloc_fire) begin
                tail <= tail + 1'b1;
            end
            if (resp_bad) begin
                err <= 1'b1;
            end
        end
    end

    // Response bookkeeping: clear the retiring head, mark legal responses.
    // A legal response can never target the retiring head (its flag is
    // already set), so the two writes never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done <= '0;
        end else begin
            if (retire) begin
                done[head] <= 1'b0;
            end
            if (resp_legal) begin
                done[resp_idx] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_orde_idx_mgr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_orde_idx_mgr
//  Description : Self-checking bench for orde_idx_mgr. A reference model of
//                the ring (ordered queue of outstanding indices plus a
//                response flag per index) predicts every output each
//                cycle; predictions are queued and a monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_orde_idx_mgr;

    localparam int NPB = 32;
    localparam int NMR = 512;
    localparam int NB  = NMR / NPB;

    logic          clk;
    logic          rst;
    logic          alloc_req;
    logic          alloc_rdy;
    logic [8:0]    alloc_idx;
    logic [NB-1:0] empty_idx_valid;
    logic [4:0]    empty_idx;
    logic [NB-1:0] oldest_idx_valid;
    logic [4:0]    oldest_idx;
    logic [NB-1:0] oldest_idx_next_valid;
    logic [4:0]    oldest_idx_next;
    logic          resp_valid;
    logic [8:0]    resp_idx;
    logic [NB-1:0] pop_idx_valid;
    logic [4:0]    pop_idx;
    logic [9:0]    count;
    logic          full;
    logic          empty;
    logic          err;

    orde_idx_mgr #(.NUM_PER_BLOCK(NPB), .NUM_MAX_RD(NMR)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .alloc_req             (alloc_req),
        .alloc_rdy             (alloc_rdy),
        .alloc_idx             (alloc_idx),
        .empty_idx_valid       (empty_idx_valid),
        .empty_idx             (empty_idx),
        .oldest_idx_valid      (oldest_idx_valid),
        .oldest_idx            (oldest_idx),
        .oldest_idx_next_valid (oldest_idx_next_valid),
        .oldest_idx_next       (oldest_idx_next),
        .resp_valid            (resp_valid),
        .resp_idx              (resp_idx),
        .pop_idx_valid         (pop_idx_valid),
        .pop_idx               (pop_idx),
        .count                 (count),
        .full                  (full),
        .empty                 (empty),
        .err                   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ar, ai, eiv, ei, ov, oi, onv, oni, pv, pi, cnt, fl, em, er;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: outstanding indices in allocation order
    int   m_q[$];
    bit   m_done[NMR];
    int   m_tail;
    bit   m_err;

    function automatic void chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        for (int i = 0; i < NMR; i++) m_done[i] = 1'b0;
        m_tail = 0;
        m_err  = 1'b0;
    endfunction

    // Outputs must sit at their reset values while rst is low
    task automatic check_reset_outputs();
        chk("rst alloc_rdy", int'(alloc_rdy), 1);
        chk("rst alloc_idx", int'(alloc_idx), 0);
        chk("rst empty_idx_valid", int'(empty_idx_valid), 1);
        chk("rst empty_idx", int'(empty_idx), 0);
        chk("rst oldest_idx_valid", int'(oldest_idx_valid), 0);
        chk("rst oldest_idx", int'(oldest_idx), 0);
        chk("rst oldest_idx_next_valid", int'(oldest_idx_next_valid), 0);
        chk("rst oldest_idx_next", int'(oldest_idx_next), 0);
        chk("rst pop_idx_valid", int'(pop_idx_valid), 0);
        chk("rst pop_idx", int'(pop_idx), 0);
        chk("rst count", int'(count), 0);
        chk("rst full", int'(full), 0);
        chk("rst empty", int'(empty), 1);
        chk("rst err", int'(err), 0);
    endtask

    // Called just after a rising edge: assert reset away from the edge,
    // check outputs asynchronously, then release between edges.
    task automatic do_reset();
        alloc_req  = 1'b0;
        resp_valid = 1'b0;
        resp_idx   = '0;
        #1 rst = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus, predict the DUT response from the model
    // and queue it for the monitor, then advance the model.
    task automatic cycle(input bit req, input bit rv, input int ridx);
        exp_t e;
        int   cnt, head, nh, ncnt;
        bit   ret, grant, legal;
        alloc_req  = req;
        resp_valid = rv;
        resp_idx   = 9'(ridx);

        cnt   = m_q.size();
        head  = (m_tail - cnt + NMR) % NMR;
        ret   = (cnt > 0) && m_done[m_q[0]];
        grant = req && (cnt < NMR);
        legal = 1'b0;
        if (rv && !m_done[ridx]) begin
            foreach (m_q[k]) if (m_q[k] == ridx) legal = 1'b1;
        end
        nh   = ret ? (head + 1) % NMR : head;
        ncnt = cnt + int'(grant) - int'(ret);

        e.ar  = (cnt < NMR) ? 1 : 0;
        e.ai  = m_tail;
        e.eiv = (cnt == NMR) ? 0 : (1 << (m_tail / NPB));
        e.ei  = m_tail % NPB;
        e.ov  = (cnt == 0) ? 0 : (1 << (head / NPB));
        e.oi  = head % NPB;
        e.onv = (ncnt == 0) ? 0 : (1 << (nh / NPB));
        e.oni = nh % NPB;
        e.pv  = ret ? (1 << (head / NPB)) : 0;
        e.pi  = ret ? head % NPB : 0;
        e.cnt = cnt;
        e.fl  = (cnt == NMR) ? 1 : 0;
        e.em  = (cnt == 0) ? 1 : 0;
        e.er  = int'(m_err);
        exp_q.push_back(e);

        if (ret) begin
            m_done[m_q[0]] = 1'b0;
            void'(m_q.pop_front());
        end
        if (legal)   m_done[ridx] = 1'b1;
        else if (rv) m_err = 1'b1;
        if (grant) begin
            m_q.push_back(m_tail);
            m_tail = (m_tail + 1) % NMR;
        end

        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("alloc_rdy", int'(alloc_rdy), e.ar);
                chk("alloc_idx", int'(alloc_idx), e.ai);
                chk("empty_idx_valid", int'(empty_idx_valid), e.eiv);
                chk("empty_idx", int'(empty_idx), e.ei);
                chk("oldest_idx_valid", int'(oldest_idx_valid), e.ov);
                chk("oldest_idx", int'(oldest_idx), e.oi);
                chk("oldest_idx_next_valid", int'(oldest_idx_next_valid), e.onv);
                chk("oldest_idx_next", int'(oldest_idx_next), e.oni);
                chk("pop_idx_valid", int'(pop_idx_valid), e.pv);
                chk("pop_idx", int'(pop_idx), e.pi);
                chk("count", int'(count), e.cnt);
                chk("full", int'(full), e.fl);
                chk("empty", int'(empty), e.em);
                chk("err", int'(err), e.er);
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ridx, span;
        bit req, rv;
        rst        = 1'b0;
        alloc_req  = 1'b0;
        resp_valid = 1'b0;
        resp_idx   = '0;
        model_reset();
        #2 check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Three allocations, then out-of-order responses 2, 0, 1
        repeat (3) cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 2);
        cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 1);
        repeat (3) cycle(1'b0, 1'b0, 0);

        // Fill to capacity, retire 0 with an alloc held across the retire
        do_reset();
        repeat (NMR) cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 5);
        cycle(1'b0, 1'b1, 5);
        cycle(1'b0, 1'b0, 0);

        // Walk head to the block boundary at 31, retire it alongside an alloc
        do_reset();
        repeat (40) cycle(1'b1, 1'b0, 0);
        for (int k = 0; k <= 30; k++) cycle(1'b0, 1'b1, k);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b1, 1'b1, 31);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 100);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b1, 33);

        // Randomized traffic with a reset in the middle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            req = ($urandom_range(0, 9) < 6);
            rv  = ($urandom_range(0, 1) == 1);
            if (m_q.size() > 0 && $urandom_range(0, 9) < 8) begin
                span = (m_q.size() > 8) ? 8 : m_q.size();
                ridx = m_q[$urandom_range(0, span - 1)];
            end else begin
                ridx = $urandom_range(0, NMR - 1);
            end
            cycle(req, rv, ridx);
        end

        @(negedge clk);
        #1;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/orde_idx_mgr.md
# orde_idx_mgr

Circular index manager for the read-ordering (orde) buffer, sitting directly upstream of the per-block L1 search/CAM stages. It allocates global entry indices in issue order for outgoing DMA reads and presents each block with its local insert index and oldest-entry pointer. It records which entries have received responses and retires them strictly in order, generating the per-block pop strobes that clear CAM status.

## Interface
- NUM_PER_BLOCK, 32: entries per CAM block; power of two.
- NUM_MAX_RD, 512: total entries; power of two, multiple of NUM_PER_BLOCK.
- NUM_BLOCKS (localparam) = NUM_MAX_RD/NUM_PER_BLOCK. IW = $clog2(NUM_MAX_RD); LW = $clog2(NUM_PER_BLOCK).
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- alloc_req  in  1  DMA read wants an entry.
- alloc_rdy  out  1  entry available (= !full).
- alloc_idx  out  IW  global index granted on fire (= tail).
- empty_idx_valid  out  NUM_BLOCKS  one-hot tail block, all-zero when full.
- empty_idx  out  LW  tail local index.
- oldest_idx_valid  out  NUM_BLOCKS  one-hot head block, all-zero when empty.
- oldest_idx  out  LW  head local index.
- oldest_idx_next_valid  out  NUM_BLOCKS  one-hot block of next-state head, zero if next state empty.
- oldest_idx_next  out  LW  next-state head local index.
- resp_valid  in  1  read response returned.
- resp_idx  in  IW  global index of the response.
- pop_idx_valid  out  NUM_BLOCKS  one-hot block being retired this cycle.
- pop_idx  out  LW  local index being retired.
- count  out  IW+1  outstanding entries.
- full, empty  out  1  count==NUM_MAX_RD / count==0.
- err  out  1  sticky: response to a non-outstanding or already-done index.

## Operation
- State: head, tail (IW bits, wrap mod NUM_MAX_RD), count, done[NUM_MAX_RD], err.
- Allocation fires on alloc_req && alloc_rdy: tail <= tail+1, count +1. alloc_idx and empty_idx* reflect the pre-fire tail.
- Block decode: block = idx[IW-1:LW], local = idx[LW-1:0].
- Response: a response is legal only if resp_idx lies in the outstanding window [head, tail) under wrap and done[resp_idx]==0. A legal response sets done[resp_idx]. An illegal response sets err and leaves all state unchanged.
- Retire: the retire condition is !empty && done[head], evaluated from registered state.
  - When it holds: pop_idx_valid[head block]=1 and pop_idx=head local, combinationally.
  - On the edge: done[head] cleared, head+1, count -1.
  - At most one retire per cycle, strictly in order.
- The next-state head is head+1 when retiring, otherwise head. oldest_idx_next* is decoded from it and from next-state emptiness (count after alloc and retire).
- Simultaneous alloc and retire: count unchanged. No bypass: when full, a same-cycle retire does not raise alloc_rdy.
- A response to head arriving in cycle t retires in t+1, never in t.

## Timing
- Reset (rst low, async): head=tail=0, count=0, done=0, err=0. Outputs during and after reset:
  - alloc_rdy=1, alloc_idx=0.
  - empty_idx_valid=1 (bit 0), empty_idx=0.
  - oldest_idx_valid=0, oldest_idx=0, oldest_idx_next_valid=0, oldest_idx_next=0.
  - pop_idx_valid=0, pop_idx=0.
  - count=0, full=0, empty=1, err=0.
- Reset mid-operation discards all outstanding entries. The first allocation after deassertion gets index 0.
- Latency:
  - Allocation takes effect on the next edge.
  - Response: done visible 1 cycle later; pop strobe in that same cycle; head advances on the following edge.
  - oldest_idx_next* is valid in the same cycle as the event that causes it.
- Wrap: index 511 is followed by 0. Block 15 is followed by block 0.
- All outputs other than pop*, oldest_idx_next*, and alloc_rdy are direct register decodes.

## Test plan
- Reset, then 3 allocs in consecutive cycles -> alloc_idx 0, 1, 2; count=3; oldest_idx_valid=0x0001, oldest_idx=0; empty_idx=3.
- Responses out of order (2, 0, 1) one per cycle -> no pop after 2; pop_idx=0 the cycle after resp 0; pops 1 and 2 in the next two consecutive cycles; empty=1 at the end.
- Allocate 512 -> full=1, empty_idx_valid=0, alloc_rdy=0. Respond 0 -> pop 0. An alloc held through that retire is not granted until the cycle after; it then gets alloc_idx=0 (wrap).
- Advance head to 31, then retire it -> pop_idx_valid=0x0001, pop_idx=31; in the same cycle oldest_idx_next_valid=0x0002, oldest_idx_next=0.
- Response to an index outside [head, tail), and a duplicate response -> err=1 and sticky; count and done unchanged.
- Alloc and retire in the same cycle -> count unchanged. Assert rst mid-stream -> all outputs take their reset values asynchronously.
